// File: rtl/regfile_wr_arbiter_if.sv
// Write-port arbitration bus: two writeback sources, issue-time reservation,
// hazard query and the registered regfile write port.
interface regfile_wr_arbiter_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
);
  localparam int unsigned NREG = 1 << AW;

  logic            req0_valid;
  logic [AW-1:0]   req0_addr;
  logic [DW-1:0]   req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [AW-1:0]   req1_addr;
  logic [DW-1:0]   req1_data;
  logic            req1_ready;
  logic            rsv_valid;
  logic [AW-1:0]   rsv_addr;
  logic [AW-1:0]   chk_a1;
  logic [AW-1:0]   chk_a2;
  logic            hazard;
  logic            we3;
  logic [AW-1:0]   wa3;
  logic [DW-1:0]   wd3;
  logic [NREG-1:0] pending;

  // Producer / pipeline side
  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output rsv_valid, rsv_addr, chk_a1, chk_a2,
    input  hazard, we3, wa3, wd3, pending
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  rsv_valid, rsv_addr, chk_a1, chk_a2,
    output hazard, we3, wa3, wd3, pending
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU and load writeback,
// with a pending-write scoreboard and read-after-write hazard detection.
module regfile_wr_arbiter #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input logic                clk,
  input logic                rst,
  regfile_wr_arbiter_if.slave bus
);
  localparam int unsigned NREG = 1 << AW;

  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } rr_e;

  rr_e             rr, rr_nxt;
  logic            grant0, grant1, xfer;
  logic [AW-1:0]   xaddr;
  logic [DW-1:0]   xdata;
  logic [NREG-1:0] pending_q, pending_nxt;
  logic            we3_q;
  logic [AW-1:0]   wa3_q;
  logic [DW-1:0]   wd3_q;
  logic            hz1, hz2;

  // Arbitration state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr <= RR_REQ0;
    else      rr <= rr_nxt;
  end

  // Grant selection, round-robin update and scoreboard next state
  always_comb begin
    grant0      = 1'b0;
    grant1      = 1'b0;
    rr_nxt      = rr;
    xaddr       = '0;
    xdata       = '0;
    pending_nxt = pending_q;

    if (bus.req0_valid && bus.req1_valid) begin
      if (rr == RR_REQ0) grant0 = 1'b1;
      else               grant1 = 1'b1;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end

    if (grant0) begin
      rr_nxt = RR_REQ1;
      xaddr  = bus.req0_addr;
      xdata  = bus.req0_data;
    end else if (grant1) begin
      rr_nxt = RR_REQ0;
      xaddr  = bus.req1_addr;
      xdata  = bus.req1_data;
    end

    // Clear first so a same-edge reservation of the same register wins
    if (xfer) pending_nxt[xaddr] = 1'b0;
    if (bus.rsv_valid && (bus.rsv_addr != '0)) pending_nxt[bus.rsv_addr] = 1'b1;
  end

  assign xfer = grant0 | grant1;

  // Registered write port and scoreboard
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we3_q     <= 1'b0;
      wa3_q     <= '0;
      wd3_q     <= '0;
      pending_q <= '0;
    end else begin
      we3_q     <= xfer && (xaddr != '0);
      pending_q <= pending_nxt;
      if (xfer) begin
        wa3_q <= xaddr;
        wd3_q <= xdata;
      end
    end
  end

  // In-flight term covers the cycle between scoreboard clear and regfile update
  always_comb begin
    hz1 = (bus.chk_a1 != '0) &&
          (pending_q[bus.chk_a1] || (we3_q && (wa3_q == bus.chk_a1)));
    hz2 = (bus.chk_a2 != '0) &&
          (pending_q[bus.chk_a2] || (we3_q && (wa3_q == bus.chk_a2)));
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.hazard     = hz1 | hz2;
  assign bus.we3        = we3_q;
  assign bus.wa3        = wa3_q;
  assign bus.wd3        = wd3_q;
  assign bus.pending    = pending_q;

endmodule
